// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: funct3 codes, FSM states,
// access sizes and the wait-state counter width.
package dmem_pkg;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } load_f3_e;

   typedef enum logic [2:0] {
      SB = 3'b000,
      SH = 3'b001,
      SW = 3'b010
   } store_f3_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } size_e;

   localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_lane_fmt.sv
// RV32I byte-lane formatter: byte enables and shifted store data, extended
// load data, plus misalign/illegal-funct3 flags for the current access.
module dmem_lane_fmt
   import dmem_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata_raw,
   output logic [3:0]  be,
   output logic [31:0] wdata_lane,
   output logic [31:0] rdata_ext,
   output logic        misalign,
   output logic        illegal
);

   size_e       size;
   logic        unsigned_ld;
   logic [1:0]  lo;
   logic [31:0] shifted;

   always_comb begin
      if (we) illegal = funct3[2] || (funct3[1:0] == 2'b11);
      else    illegal = (funct3[1:0] == 2'b11) || (funct3 == 3'b110);

      // Illegal codes fall back to a full-word access.
      size        = illegal ? SZ_W : size_e'(funct3[1:0]);
      unsigned_ld = funct3[2] && !illegal && !we;
      misalign    = ((size == SZ_H) && addr_lo[0]) || ((size == SZ_W) && (addr_lo != 2'b00));

      // Lane offset forced to natural alignment; only matters when errors are not checked.
      lo = addr_lo;
      if (size == SZ_H) lo[0] = 1'b0;
      if (size == SZ_W) lo    = 2'b00;

      shifted    = rdata_raw >> {lo, 3'b000};
      wdata_lane = wdata << {lo, 3'b000};

      case (size)
         SZ_B: begin
            be        = 4'b0001 << lo;
            rdata_ext = {{24{~unsigned_ld & shifted[7]}}, shifted[7:0]};
         end
         SZ_H: begin
            be        = 4'b0011 << lo;
            rdata_ext = {{16{~unsigned_ld & shifted[15]}}, shifted[15:0]};
         end
         default: begin
            be        = 4'b1111;
            rdata_ext = shifted;
         end
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, LATENCY wait states, then a
// held response. Define DMEM_ERR_CHECK_EN to flag misaligned/illegal/out-of-range accesses.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   state_e             state, state_d;
   logic [CNT_W-1:0]   cnt;
   logic               we_q;
   logic [2:0]         f3_q;
   logic [31:0]        addr_q;
   logic [31:0]        wdata_q;

   logic [31:0]        mem [DEPTH_WORDS];
   logic [IDX_W-1:0]   idx;
   logic [31:0]        rdata_raw;
   logic [3:0]         be;
   logic [31:0]        wdata_lane;
   logic [31:0]        rdata_ext;
   logic               misalign;
   logic               illegal;
   logic               err;
   logic               commit;

   // Index takes the low word-address bits, so it wraps when range is unchecked.
   assign idx       = addr_q[IDX_W+1:2];
   assign rdata_raw = mem[idx];

   dmem_lane_fmt u_lane_fmt (
      .we         (we_q),
      .funct3     (f3_q),
      .addr_lo    (addr_q[1:0]),
      .wdata      (wdata_q),
      .rdata_raw  (rdata_raw),
      .be         (be),
      .wdata_lane (wdata_lane),
      .rdata_ext  (rdata_ext),
      .misalign   (misalign),
      .illegal    (illegal)
   );

`ifdef DMEM_ERR_CHECK_EN
   logic range_err;
   assign range_err = ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
   assign err       = misalign || illegal || range_err;
`else
   logic unused_flags;
   assign unused_flags = ^{misalign, illegal, addr_q[31:IDX_W+2]};
   assign err          = 1'b0;
`endif

   assign commit    = (state == BUSY) && (cnt == '0);
   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (req_valid) state_d = BUSY;
         BUSY:    if (cnt == '0) state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         we_q      <= 1'b0;
         f3_q      <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_d;
         if ((state == IDLE) && req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt     <= CNT_W'(LATENCY);
         end
         if ((state == BUSY) && (cnt != '0)) cnt <= cnt - 1'b1;
         if (commit) begin
            rsp_rdata <= (we_q || err) ? 32'h0 : rdata_ext;
            rsp_err   <= err;
         end
      end
   end

   // Storage is deliberately not reset; reset forces IDLE, which blocks commit.
   always_ff @(posedge clk) begin
      if (commit && we_q && !err) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wdata_lane[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for function,
// backpressure and reset, and a LATENCY=0 instance for throughput timing.
module tb_dmem_responder;
   import dmem_pkg::*;

   localparam int DEPTH = 1024;
   localparam int LAT   = 2;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        req_valid, req_we, rsp_ready;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   logic        z_req_valid, z_req_we, z_rsp_ready;
   logic [2:0]  z_req_funct3;
   logic [31:0] z_req_addr, z_req_wdata;
   logic        z_req_ready, z_rsp_valid, z_rsp_err;
   logic [31:0] z_rsp_rdata;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
      .req_funct3(z_req_funct3), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
      .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
      .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
   );

   task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // One full transaction; 'hold' cycles of rsp_ready=0 with a competing request driven.
   task automatic do_txn(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                         input logic [31:0] exp_rdata, input logic exp_err);
      int lat;
      int ready_hi;
      @(negedge clk);
      check_vec({tag, ".idle_ready"}, req_ready, 1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      ready_hi = 0;
      while (lat < 40) begin
         @(posedge clk);
         lat++;
         #1;
         if (rsp_valid) break;
         if (req_ready) ready_hi++;
      end
      check_vec({tag, ".latency"}, lat, LAT + 1);
      check_vec({tag, ".busy_ready"}, ready_hi, 0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         req_valid  = 1'b1;
         req_we     = 1'b1;
         req_funct3 = SW;
         req_addr   = addr;
         req_wdata  = 32'h0BADF00D;
         check_vec({tag, ".hold_valid"}, rsp_valid, 1);
         check_vec({tag, ".hold_rdata"}, rsp_rdata, exp_rdata);
         check_vec({tag, ".hold_err"}, rsp_err, exp_err);
         check_vec({tag, ".hold_ready"}, req_ready, 0);
      end
      @(negedge clk);
      req_valid = 1'b0;
      check_vec({tag, ".rdata"}, rsp_rdata, exp_rdata);
      check_vec({tag, ".err"}, rsp_err, exp_err);
      check_vec({tag, ".resp_ready"}, req_ready, 0);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      check_vec({tag, ".done_valid"}, rsp_valid, 0);
      check_vec({tag, ".done_ready"}, req_ready, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_vec({tag, ".req_ready"}, req_ready, 1);
      check_vec({tag, ".rsp_valid"}, rsp_valid, 0);
      check_vec({tag, ".rsp_rdata"}, rsp_rdata, 0);
      check_vec({tag, ".rsp_err"}, rsp_err, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      req_valid   = 1'b0; req_we = 1'b0; req_funct3 = '0;
      req_addr    = '0;   req_wdata = '0; rsp_ready = 1'b0;
      z_req_valid = 1'b0; z_req_we = 1'b0; z_req_funct3 = '0;
      z_req_addr  = '0;   z_req_wdata = '0; z_rsp_ready = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      check_vec("reset.z_req_ready", z_req_ready, 1);
      check_vec("reset.z_rsp_valid", z_rsp_valid, 0);
      @(negedge clk) rst_n = 1'b1;

      // Basic word store/load and byte/half formatting
      do_txn("sw10", 1'b1, SW, 32'h10, 32'hDEADBEEF, 0, 32'h0, 1'b0);
      do_txn("lw10", 1'b0, LW, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1'b0);
      do_txn("sb13", 1'b1, SB, 32'h13, 32'h00000080, 0, 32'h0, 1'b0);
      do_txn("sh10", 1'b1, SH, 32'h10, 32'h00001234, 0, 32'h0, 1'b0);
      do_txn("lw10b", 1'b0, LW, 32'h10, 32'h0, 0, 32'h80AD1234, 1'b0);
      do_txn("lb13", 1'b0, LB, 32'h13, 32'h0, 0, 32'hFFFFFF80, 1'b0);
      do_txn("lbu13", 1'b0, LBU, 32'h13, 32'h0, 0, 32'h00000080, 1'b0);
      do_txn("lh12", 1'b0, LH, 32'h12, 32'h0, 0, 32'hFFFF80AD, 1'b0);
      do_txn("lhu12", 1'b0, LHU, 32'h12, 32'h0, 0, 32'h000080AD, 1'b0);

`ifdef DMEM_ERR_CHECK_EN
      do_txn("err_lw11", 1'b0, LW, 32'h11, 32'h0, 0, 32'h0, 1'b1);
      do_txn("err_sh13", 1'b1, SH, 32'h13, 32'h0000FFFF, 0, 32'h0, 1'b1);
      do_txn("err_range", 1'b0, LW, 32'(4 * DEPTH), 32'h0, 0, 32'h0, 1'b1);
      do_txn("err_f3", 1'b0, 3'b011, 32'h10, 32'h0, 0, 32'h0, 1'b1);
      do_txn("err_after", 1'b0, LW, 32'h10, 32'h0, 0, 32'h80AD1234, 1'b0);
`else
      do_txn("fa_lw11", 1'b0, LW, 32'h11, 32'h0, 0, 32'h80AD1234, 1'b0);
      do_txn("fa_lh13", 1'b0, LH, 32'h13, 32'h0, 0, 32'hFFFF80AD, 1'b0);
      do_txn("wrap_lw", 1'b0, LW, 32'(4 * DEPTH + 32'h10), 32'h0, 0, 32'h80AD1234, 1'b0);
      do_txn("f3_as_lw", 1'b0, 3'b011, 32'h10, 32'h0, 0, 32'h80AD1234, 1'b0);
      do_txn("fa_sh13", 1'b1, SH, 32'h13, 32'h000055AA, 0, 32'h0, 1'b0);
      do_txn("fa_after", 1'b0, LW, 32'h10, 32'h0, 0, 32'h55AA1234, 1'b0);
      do_txn("restore", 1'b1, SW, 32'h10, 32'h80AD1234, 0, 32'h0, 1'b0);
`endif

      // Backpressure: response held 5 cycles, competing store must not land
      do_txn("bp", 1'b0, LW, 32'h10, 32'h0, 5, 32'h80AD1234, 1'b0);
      do_txn("bp_after", 1'b0, LW, 32'h10, 32'h0, 0, 32'h80AD1234, 1'b0);

      // Reset during BUSY aborts the store
      do_txn("sw20", 1'b1, SW, 32'h20, 32'hCAFEF00D, 0, 32'h0, 1'b0);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = SW;
      req_addr  = 32'h20; req_wdata = 32'h11111111;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check_reset_outputs("rst_busy");
      @(posedge clk);
      #1 check_reset_outputs("rst_hold");
      @(negedge clk) rst_n = 1'b1;
      do_txn("lw20", 1'b0, LW, 32'h20, 32'h0, 0, 32'hCAFEF00D, 1'b0);

      // LATENCY=0 instance, back-to-back stores with rsp_ready high
      @(negedge clk);
      z_req_valid = 1'b1; z_req_we = 1'b1; z_req_funct3 = SW;
      z_req_addr  = 32'h0; z_req_wdata = 32'h5A5A5A5A; z_rsp_ready = 1'b1;
      for (int e = 1; e <= 9; e++) begin
         @(posedge clk);
         #1;
         check_vec($sformatf("lat0.valid_e%0d", e), z_rsp_valid, (e % 3) == 2);
         check_vec($sformatf("lat0.ready_e%0d", e), z_req_ready, (e % 3) == 0);
         if ((e % 3) == 2) check_vec($sformatf("lat0.err_e%0d", e), z_rsp_err, 0);
      end
      @(negedge clk);
      z_req_valid = 1'b0;
      z_rsp_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
